// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the terminal UART transmit register port between two byte producers.
// Optional build macro UART_ARB_LOCK_EN lets the current owner keep priority via req*_lock.
module uart_tx_arbiter #(
  parameter int POLL_TIMEOUT = 1023,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_lock,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic       uart_cs,
  output logic       uart_we,
  output logic [1:0] uart_addr,
  output logic [7:0] uart_wdata,
  output logic       uart_wdata_en,
  input  logic [7:0] uart_rdata,
  output logic       busy,
  output logic       owner,
  output logic       timeout_err,
  input  logic       timeout_clr
);

  localparam int PCNT_W = $clog2(POLL_TIMEOUT + 1);
  localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] POLL_MAX = PCNT_W'(POLL_TIMEOUT);
  localparam logic [GCNT_W-1:0] GAP_LAST = GCNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, POLL, WRITE, GAP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PCNT_W-1:0] poll_cnt;
  logic [GCNT_W-1:0] gap_cnt;
  logic              pointer;
  logic              owner_q;
  logic [7:0]        wdata_q;
  logic              timeout_q;

  logic any_valid;
  logic grant;
  logic tx_busy;
  logic poll_expired;
  logic gap_done;
  logic lock_owner;
  logic unused_rdata;

  assign any_valid    = req0_valid | req1_valid;
  // Contention goes to the favoured side; otherwise whoever is asking.
  assign grant        = (req0_valid & req1_valid) ? pointer : req1_valid;
  assign tx_busy      = uart_rdata[1];
  assign poll_expired = (poll_cnt == POLL_MAX);
  assign gap_done     = (gap_cnt == GAP_LAST);
  assign unused_rdata = ^{uart_rdata[7:2], uart_rdata[0]};

`ifdef UART_ARB_LOCK_EN
  assign lock_owner = owner_q ? req1_lock : req0_lock;
`else
  logic unused_lock;
  assign unused_lock = ^{req0_lock, req1_lock};
  assign lock_owner  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (any_valid) state_nxt = POLL;
      POLL: begin
        if (!tx_busy)          state_nxt = WRITE;
        else if (poll_expired) state_nxt = GAP;
      end
      WRITE: state_nxt = GAP;
      GAP:   if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt  <= '0;
      gap_cnt   <= '0;
      pointer   <= 1'b0;
      owner_q   <= 1'b0;
      wdata_q   <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == IDLE && any_valid) begin
        owner_q  <= grant;
        wdata_q  <= grant ? req1_data : req0_data;
        poll_cnt <= '0;
      end
      if (state == POLL && tx_busy && !poll_expired)
        poll_cnt <= poll_cnt + 1'b1;
      // An abandoned grant hands priority to the other side and never honours lock.
      if (state == POLL && tx_busy && poll_expired)
        pointer <= ~owner_q;
      if (state == WRITE)
        pointer <= lock_owner ? owner_q : ~owner_q;
      if (state == POLL && tx_busy && poll_expired) timeout_q <= 1'b1;
      else if (timeout_clr)                         timeout_q <= 1'b0;
    end
  end

  always_comb begin
    uart_cs       = 1'b0;
    uart_we       = 1'b0;
    uart_addr     = 2'b00;
    uart_wdata_en = 1'b0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    case (state)
      POLL: begin
        uart_cs   = 1'b1;
        uart_addr = 2'b01;
      end
      WRITE: begin
        uart_cs       = 1'b1;
        uart_we       = 1'b1;
        uart_wdata_en = 1'b1;
        req0_ready    = ~owner_q;
        req1_ready    = owner_q;
      end
      default: ;
    endcase
  end

  assign uart_wdata  = wdata_q;
  assign busy        = (state != IDLE);
  assign owner       = owner_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level schedule model predicts every bus cycle.
module tb_uart_tx_arbiter;

  localparam int PT = 4;
  localparam int G  = 2;
  localparam int NC = 3000;
  localparam int AW = NC + 64;
`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_lock, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_lock, req1_ready;
  logic [7:0] req1_data;
  logic       uart_cs, uart_we, uart_wdata_en;
  logic [1:0] uart_addr;
  logic [7:0] uart_wdata, uart_rdata;
  logic       busy, owner, timeout_err, timeout_clr;

  uart_tx_arbiter #(.POLL_TIMEOUT(PT), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_lock(req1_lock), .req1_ready(req1_ready),
    .uart_cs(uart_cs), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_wdata_en(uart_wdata_en), .uart_rdata(uart_rdata),
    .busy(busy), .owner(owner), .timeout_err(timeout_err), .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference schedule: per-cycle expected bus activity, filled in when a grant is decided.
  bit         busy_pat [AW];
  bit         e_cs [AW], e_we [AW], e_poll [AW], e_busy [AW], e_rdy0 [AW], e_rdy1 [AW];
  logic [7:0] e_wd [AW];
  logic [7:0] q0 [$], q1 [$];
  int  avail0 = 0, avail1 = 0;
  int  next_idle = 0, to_set = -1, own_switch = -1;
  bit  favour = 1'b0, own_now = 1'b0, own_next = 1'b0, exp_to = 1'b0;
  bit  lk0, lk1;

  task automatic plan(input int n, input bit g, input logic [7:0] d);
    int found;
    int last;
    found = -1;
    own_next   = g;
    own_switch = n + 1;
    for (int p = n + 1; p <= n + 1 + PT; p++)
      if (found < 0 && !busy_pat[p]) found = p;
    if (found >= 0) begin
      for (int p = n + 1; p <= found; p++) begin
        e_cs[p] = 1'b1; e_poll[p] = 1'b1;
      end
      e_cs[found + 1] = 1'b1;
      e_we[found + 1] = 1'b1;
      e_wd[found + 1] = d;
      if (g) e_rdy1[found + 1] = 1'b1;
      else   e_rdy0[found + 1] = 1'b1;
      next_idle = found + G + 2;
      favour = (LOCK_EN && (g ? lk1 : lk0)) ? g : !g;
    end else begin
      last = n + 1 + PT;
      for (int p = n + 1; p <= last; p++) begin
        e_cs[p] = 1'b1; e_poll[p] = 1'b1;
      end
      to_set    = last;
      next_idle = last + G + 1;
      favour    = !g;
    end
    for (int p = n + 1; p < next_idle; p++) e_busy[p] = 1'b1;
  endtask

  initial begin
    int  i;
    int  mode;
    int  len;
    bit  v0, v1, g, clr, seen;
    logic [7:0] rd;

    rst = 1'b0;
    req0_valid = 0; req0_data = 0; req0_lock = 0;
    req1_valid = 0; req1_data = 0; req1_lock = 0;
    uart_rdata = 0; timeout_clr = 0;
    lk0 = 1'($urandom_range(0, 1));
    lk1 = 1'($urandom_range(0, 1));

    for (int k = 0; k < 200; k++) begin
      q0.push_back(8'($urandom));
      q1.push_back(8'($urandom));
    end
    i = 0;
    while (i < AW) begin
      mode = $urandom_range(0, 7);
      len  = $urandom_range(3, 12);
      for (int k = 0; k < len && i < AW; k++) begin
        busy_pat[i] = (mode == 0) ? 1'b1 : (mode < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        i++;
      end
    end

    #3 rst = 1'b1;
    #1;
    chk("rst_cs", uart_cs, 0);
    chk("rst_we", uart_we, 0);
    chk("rst_addr", uart_addr, 0);
    chk("rst_wdata", uart_wdata, 0);
    chk("rst_wen", uart_wdata_en, 0);
    chk("rst_rdy", {req1_ready, req0_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_to", timeout_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    req0_lock = lk0;
    req1_lock = lk1;

    for (int c = 0; c < NC; c++) begin
      @(posedge clk); #1;
      if (c == own_switch) own_now = own_next;
      v0 = (q0.size() > 0) && (c >= avail0) && (c < NC - 40);
      v1 = (q1.size() > 0) && (c >= avail1) && (c < NC - 40);
      req0_valid = v0; req0_data = v0 ? q0[0] : 8'h00;
      req1_valid = v1; req1_data = v1 ? q1[0] : 8'h00;
      rd = 8'($urandom);
      rd[1] = busy_pat[c];
      uart_rdata = rd;
      clr = ($urandom_range(0, 7) == 0);
      timeout_clr = clr;
      if (c == next_idle) begin
        if (v0 || v1) begin
          g = (v0 && v1) ? favour : v1;
          plan(c, g, g ? q1[0] : q0[0]);
        end else begin
          next_idle = c + 1;
        end
      end
      @(negedge clk);
      chk($sformatf("cs@%0d", c), uart_cs, e_cs[c]);
      chk($sformatf("we@%0d", c), uart_we, e_we[c]);
      chk($sformatf("wen@%0d", c), uart_wdata_en, e_we[c]);
      chk($sformatf("addr@%0d", c), uart_addr, e_poll[c] ? 2'b01 : 2'b00);
      chk($sformatf("rdy0@%0d", c), req0_ready, e_rdy0[c]);
      chk($sformatf("rdy1@%0d", c), req1_ready, e_rdy1[c]);
      chk($sformatf("busy@%0d", c), busy, e_busy[c]);
      chk($sformatf("owner@%0d", c), owner, own_now);
      chk($sformatf("to@%0d", c), timeout_err, exp_to);
      if (e_we[c]) chk($sformatf("wdata@%0d", c), uart_wdata, e_wd[c]);
      if (req0_ready && q0.size() > 0) begin
        void'(q0.pop_front());
        avail0 = c + 1 + $urandom_range(0, 6);
      end
      if (req1_ready && q1.size() > 0) begin
        void'(q1.pop_front());
        avail1 = c + 1 + $urandom_range(0, 6);
      end
      if (c == to_set) exp_to = 1'b1;
      else if (clr)    exp_to = 1'b0;
    end

    // Reset asserted while a byte is on the bus must kill the write at once.
    @(posedge clk); #1;
    timeout_clr = 1'b0;
    uart_rdata  = 8'h00;
    req0_valid  = 1'b1;
    req0_data   = 8'h5A;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (uart_we) seen = 1'b1;
    end
    chk("write_reached", seen, 1);
    rst = 1'b1;
    #1;
    chk("mid_cs", uart_cs, 0);
    chk("mid_we", uart_we, 0);
    chk("mid_wen", uart_wdata_en, 0);
    chk("mid_rdy", {req1_ready, req0_ready}, 0);
    chk("mid_addr", uart_addr, 0);
    chk("mid_wdata", uart_wdata, 0);
    chk("mid_busy", busy, 0);
    chk("mid_owner", owner, 0);
    chk("mid_to", timeout_err, 0);
    req0_valid = 1'b0;
    @(negedge clk) rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
